// File: rtl/sequence_counter_if.sv
// rtl/sequence_counter_if.sv - control, feedback and status bundle for the time-code sequencer
interface sequence_counter_if;
  logic       start;
  logic       halt;
  logic       clr;
  logic       err_clr;
  logic [7:0] t_fb;
  logic [2:0] t_code;
  logic       running;
  logic [2:0] enc_code;
  logic       enc_valid;
  logic       fb_err;
  logic [7:0] instr_cnt;

  modport master (
    output start, halt, clr, err_clr, t_fb,
    input  t_code, running, enc_code, enc_valid, fb_err, instr_cnt
  );

  modport slave (
    input  start, halt, clr, err_clr, t_fb,
    output t_code, running, enc_code, enc_valid, fb_err, instr_cnt
  );
endinterface

// File: rtl/sequence_counter.sv
// rtl/sequence_counter.sv - instruction time-code sequencer with decoder feedback check
module sequence_counter #(
  parameter int LAST_T = 7
) (
  input  logic              clk,
  input  logic              rst,
  sequence_counter_if.slave bus
);

  localparam logic [2:0] LP_LAST_T = 3'(LAST_T);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_t_code;
  logic       r_running;
  logic       r_fb_err;
  logic [7:0] r_instr_cnt;

  logic [2:0] w_enc_code;
  logic       w_enc_valid;
  logic       w_fb_mismatch;
  logic       w_go;

  // Ascending scan so the highest set line overwrites lower ones.
  always_comb begin
    w_enc_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.t_fb[i]) w_enc_code = 3'(i);
    end
  end

  assign w_enc_valid   = (bus.t_fb != 8'd0) && ((bus.t_fb & (bus.t_fb - 8'd1)) == 8'd0);
  assign w_fb_mismatch = !w_enc_valid || (w_enc_code != r_t_code);
  assign w_go          = bus.start && !bus.halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t_code    <= 3'd0;
      r_running   <= 1'b0;
      r_fb_err    <= 1'b0;
      r_instr_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
        end
        S_RUN: if (bus.halt) begin
          r_state   <= S_STOP;
          r_running <= 1'b0;
        end
        S_STOP: if (w_go) begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase

      // Halt freezes the code on the same edge the state leaves RUN.
      if (bus.clr)
        r_t_code <= 3'd0;
      else if (r_state == S_RUN && !bus.halt)
        r_t_code <= (r_t_code == LP_LAST_T) ? 3'd0 : r_t_code + 3'd1;

      if (bus.clr && r_state == S_RUN)
        r_instr_cnt <= r_instr_cnt + 8'd1;

      if (r_state != S_IDLE && w_fb_mismatch)
        r_fb_err <= 1'b1;
      else if (bus.err_clr)
        r_fb_err <= 1'b0;
    end
  end

  assign bus.t_code    = r_t_code;
  assign bus.running   = r_running;
  assign bus.enc_code  = w_enc_code;
  assign bus.enc_valid = w_enc_valid;
  assign bus.fb_err    = r_fb_err;
  assign bus.instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_sequence_counter.sv
// tb/tb_sequence_counter.sv - directed self-checking bench for sequence_counter
module tb_sequence_counter;
  logic       clk;
  logic       rst;
  logic       start, halt, clr, err_clr;
  logic       fb_auto;
  logic [7:0] fb_force;
  int         checks;
  int         errors;

  sequence_counter_if ia ();
  sequence_counter_if ib ();

  assign ia.start   = start;
  assign ia.halt    = halt;
  assign ia.clr     = clr;
  assign ia.err_clr = err_clr;
  assign ia.t_fb    = fb_auto ? (8'd1 << ia.t_code) : fb_force;

  assign ib.start   = start;
  assign ib.halt    = halt;
  assign ib.clr     = clr;
  assign ib.err_clr = err_clr;
  assign ib.t_fb    = 8'd1 << ib.t_code;

  sequence_counter #(.LAST_T(7)) u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  sequence_counter #(.LAST_T(4)) u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; halt = 1'b0; clr = 1'b0; err_clr = 1'b0;
    fb_auto = 1'b1; fb_force = 8'd0;

    #2;
    check("rst_t_code", 32'(ia.t_code), 0);
    check("rst_running", 32'(ia.running), 0);
    check("rst_fb_err", 32'(ia.fb_err), 0);
    check("rst_instr_cnt", 32'(ia.instr_cnt), 0);

    start = 1'b1;
    step();
    check("start_during_rst", 32'(ia.running), 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("idle_after_rst", 32'(ia.running), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", 32'(ia.running), 1);
    check("start_t_code", 32'(ia.t_code), 0);
    check("b_start_t_code", 32'(ib.t_code), 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("seq_a_t_code", 32'(ia.t_code), 32'(i % 8));
      check("seq_b_t_code", 32'(ib.t_code), 32'(i % 5));
    end
    check("seq_a_fb_err", 32'(ia.fb_err), 0);
    check("seq_a_running", 32'(ia.running), 1);
    check("wrap_no_count_a", 32'(ia.instr_cnt), 0);
    check("wrap_no_count_b", 32'(ib.instr_cnt), 0);

    step(); step();
    check("pre_clr_t_code", 32'(ia.t_code), 3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_run_t_code", 32'(ia.t_code), 0);
    check("clr_run_cnt", 32'(ia.instr_cnt), 1);
    step();
    check("post_clr_inc", 32'(ia.t_code), 1);

    step(); step(); step(); step();
    check("pre_halt_t_code", 32'(ia.t_code), 5);
    start = 1'b1; halt = 1'b1;
    step();
    start = 1'b0; halt = 1'b0;
    check("halt_prio_running", 32'(ia.running), 0);
    check("halt_freeze", 32'(ia.t_code), 5);
    step();
    check("stop_hold", 32'(ia.t_code), 5);
    check("stop_fb_ok", 32'(ia.fb_err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_running", 32'(ia.running), 1);
    check("resume_edge_t_code", 32'(ia.t_code), 5);
    step();
    check("resume_inc", 32'(ia.t_code), 6);

    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt2_t_code", 32'(ia.t_code), 6);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_stop_t_code", 32'(ia.t_code), 0);
    check("clr_stop_cnt", 32'(ia.instr_cnt), 1);
    check("clr_stop_running", 32'(ia.running), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_running", 32'(ia.running), 1);

    fb_auto = 1'b0; fb_force = 8'b1000_0000;
    #1;
    check("enc_msb_code", 32'(ia.enc_code), 7);
    check("enc_msb_valid", 32'(ia.enc_valid), 1);
    fb_force = 8'b0000_0110;
    #1;
    check("enc_multi_code", 32'(ia.enc_code), 2);
    check("enc_multi_valid", 32'(ia.enc_valid), 0);
    step();
    check("fb_err_set", 32'(ia.fb_err), 1);
    fb_auto = 1'b1;
    step();
    check("fb_err_sticky", 32'(ia.fb_err), 1);
    err_clr = 1'b1;
    step();
    check("fb_err_cleared", 32'(ia.fb_err), 0);
    fb_auto = 1'b0; fb_force = 8'd0;
    #1;
    check("enc_zero_code", 32'(ia.enc_code), 0);
    check("enc_zero_valid", 32'(ia.enc_valid), 0);
    step();
    check("fb_err_set_wins", 32'(ia.fb_err), 1);
    fb_auto = 1'b1;
    step();
    err_clr = 1'b0;
    check("fb_err_cleared2", 32'(ia.fb_err), 0);

    clr = 1'b1;
    for (int i = 0; i < 8; i++) step();
    clr = 1'b0;
    check("cnt_nine", 32'(ia.instr_cnt), 9);
    check("cnt_nine_t_code", 32'(ia.t_code), 0);
    for (int i = 0; i < 5; i++) step();
    fb_auto = 1'b0; fb_force = 8'd0;
    step();
    check("pre_rst_t_code", 32'(ia.t_code), 6);
    check("pre_rst_fb_err", 32'(ia.fb_err), 1);
    check("pre_rst_running", 32'(ia.running), 1);

    #3;
    rst = 1'b1;
    #1;
    check("async_t_code", 32'(ia.t_code), 0);
    check("async_running", 32'(ia.running), 0);
    check("async_fb_err", 32'(ia.fb_err), 0);
    check("async_cnt", 32'(ia.instr_cnt), 0);
    step();
    rst = 1'b0;
    step(); step();
    check("post_rst_idle", 32'(ia.running), 0);
    check("post_rst_t_code", 32'(ia.t_code), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_idle_cnt", 32'(ia.instr_cnt), 0);
    check("idle_fb_ignored", 32'(ia.fb_err), 0);
    fb_auto = 1'b1;

    start = 1'b1;
    step();
    start = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 255; i++) step();
    check("cnt_255", 32'(ia.instr_cnt), 255);
    step();
    clr = 1'b0;
    check("cnt_wrap", 32'(ia.instr_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
